// File: rtl/axi4_lat_slave_ram.sv
// AXI4 slave RAM model: programmable base/depth, read/write response latency,
// FIXED/INCR/WRAP and narrow bursts, byte strobes, per-beat DECERR/SLVERR.
//
// state    | meaning
// RD_IDLE  | arready high, waiting for a read request
// RD_WAIT  | latency down-counter running before the first beat
// RD_BURST | presenting beats, one per rready handshake
// WR_IDLE  | awready high, waiting for a write request
// WR_DATA  | wready high, accepting len+1 beats
// WR_WAIT  | latency down-counter running before the response
// WR_RESP  | bvalid held until bready
module axi4_lat_slave_ram #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 512,
  parameter int                    ID_WIDTH   = 16,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LATENCY = 4,
  parameter int                    WR_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam logic [15:0] RD_WAIT_INIT = 16'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam logic [15:0] WR_WAIT_INIT = 16'((WR_LATENCY > 1) ? WR_LATENCY - 2 : 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_WAIT, WR_RESP} wr_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> OFF_W;
    return (a >= BASE_ADDR) && (off < ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> OFF_W;
    return IDX_W'(off);
  endfunction

  function automatic logic is_illegal(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (int'(size) > OFF_W) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  // WRAP uses a mask, so it is only exact for the legal power-of-two lengths;
  // illegal bursts never touch memory, so their addresses do not matter.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, incr, wmask;
    step  = ADDR_WIDTH'(1) << size;
    incr  = (a & ~(step - ADDR_WIDTH'(1))) + step;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    if (burst == BURST_FIXED)     return a;
    else if (burst == BURST_WRAP) return (a & ~wmask) | (incr & wmask);
    else                          return incr;
  endfunction

  // ---------------- read channel ----------------
  rd_state_t             rd_state, rd_state_nx;
  logic                  rd_fetch;
  logic [15:0]           rd_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr, cur_addr;
  logic [7:0]            rd_len, rd_beat, cur_len, cur_beat;
  logic [2:0]            rd_size, cur_size;
  logic [1:0]            rd_burst, cur_burst;
  logic                  rd_ill, cur_ill;
  logic                  ar_hs, r_hs;

  assign ar_hs = s_axi_arready & s_axi_arvalid;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  // With RD_LATENCY=1 beat 0 is fetched on the AR handshake itself, straight from the AR bus.
  always_comb begin
    if (rd_state == RD_IDLE) begin
      cur_addr  = s_axi_araddr;
      cur_len   = s_axi_arlen;
      cur_size  = s_axi_arsize;
      cur_burst = s_axi_arburst;
      cur_ill   = is_illegal(s_axi_arlen, s_axi_arsize, s_axi_arburst);
      cur_beat  = '0;
    end else begin
      cur_addr  = rd_addr;
      cur_len   = rd_len;
      cur_size  = rd_size;
      cur_burst = rd_burst;
      cur_ill   = rd_ill;
      cur_beat  = rd_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nx;
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_fetch    = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (ar_hs) begin
          if (RD_LATENCY <= 1) begin
            rd_state_nx = RD_BURST;
            rd_fetch    = 1'b1;
          end else begin
            rd_state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rd_cnt == 16'd0) begin
          rd_state_nx = RD_BURST;
          rd_fetch    = 1'b1;
        end
      end
      RD_BURST: begin
        if (r_hs) begin
          if (s_axi_rlast) rd_state_nx = RD_IDLE;
          else             rd_fetch    = 1'b1;
        end
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      rd_cnt        <= '0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_size       <= '0;
      rd_burst      <= '0;
      rd_ill        <= 1'b0;
      rd_beat       <= '0;
    end else begin
      s_axi_arready <= (rd_state_nx == RD_IDLE);
      s_axi_rvalid  <= (rd_state_nx == RD_BURST);
      if (ar_hs) begin
        s_axi_rid   <= s_axi_arid;
        s_axi_rlast <= 1'b0;
        rd_len      <= s_axi_arlen;
        rd_size     <= s_axi_arsize;
        rd_burst    <= s_axi_arburst;
        rd_ill      <= is_illegal(s_axi_arlen, s_axi_arsize, s_axi_arburst);
        rd_cnt      <= RD_WAIT_INIT;
        rd_addr     <= s_axi_araddr;
        rd_beat     <= '0;
      end else if (rd_state == RD_WAIT) begin
        rd_cnt <= rd_cnt - 16'd1;
      end
      if (rd_fetch) begin
        rd_addr     <= next_addr(cur_addr, cur_len, cur_size, cur_burst);
        rd_beat     <= cur_beat + 8'd1;
        s_axi_rlast <= (cur_beat == cur_len);
        if (cur_ill)                 s_axi_rresp <= RESP_SLVERR;
        else if (!in_range(cur_addr)) s_axi_rresp <= RESP_DECERR;
        else                         s_axi_rresp <= RESP_OKAY;
      end
    end
  end

  // Non-blocking read of mem returns the pre-write word on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst)
      s_axi_rdata <= '0;
    else if (rd_fetch)
      s_axi_rdata <= (cur_ill || !in_range(cur_addr)) ? '0 : mem[word_idx(cur_addr)];
  end

  // ---------------- write channel ----------------
  wr_state_t             wr_state, wr_state_nx;
  logic [15:0]           wr_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len, wr_beat;
  logic [2:0]            wr_size;
  logic [1:0]            wr_burst;
  logic                  wr_ill, wr_slv, wr_dec;
  logic                  wr_slv_nx, wr_dec_nx, wr_last_beat;
  logic                  aw_hs, w_hs, b_hs;

  assign aw_hs        = s_axi_awready & s_axi_awvalid;
  assign w_hs         = s_axi_wready & s_axi_wvalid;
  assign b_hs         = s_axi_bvalid & s_axi_bready;
  assign wr_last_beat = (wr_beat == wr_len);
  assign wr_slv_nx    = wr_slv | (w_hs & (s_axi_wlast != wr_last_beat));
  assign wr_dec_nx    = wr_dec | (w_hs & ~in_range(wr_addr));

  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_nx;
  end

  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_hs) wr_state_nx = WR_DATA;
      WR_DATA: begin
        if (w_hs && wr_last_beat)
          wr_state_nx = (WR_LATENCY <= 1) ? WR_RESP : WR_WAIT;
      end
      WR_WAIT: if (wr_cnt == 16'd0) wr_state_nx = WR_RESP;
      WR_RESP: if (b_hs) wr_state_nx = WR_IDLE;
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      wr_cnt        <= '0;
      wr_addr       <= '0;
      wr_len        <= '0;
      wr_size       <= '0;
      wr_burst      <= '0;
      wr_beat       <= '0;
      wr_ill        <= 1'b0;
      wr_slv        <= 1'b0;
      wr_dec        <= 1'b0;
    end else begin
      s_axi_awready <= (wr_state_nx == WR_IDLE);
      s_axi_wready  <= (wr_state_nx == WR_DATA);
      s_axi_bvalid  <= (wr_state_nx == WR_RESP);
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        wr_addr   <= s_axi_awaddr;
        wr_len    <= s_axi_awlen;
        wr_size   <= s_axi_awsize;
        wr_burst  <= s_axi_awburst;
        wr_beat   <= '0;
        wr_ill    <= is_illegal(s_axi_awlen, s_axi_awsize, s_axi_awburst);
        wr_slv    <= is_illegal(s_axi_awlen, s_axi_awsize, s_axi_awburst);
        wr_dec    <= 1'b0;
      end
      if (w_hs) begin
        wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
        wr_beat <= wr_beat + 8'd1;
        wr_slv  <= wr_slv_nx;
        wr_dec  <= wr_dec_nx;
        wr_cnt  <= WR_WAIT_INIT;
      end else if (wr_state == WR_WAIT) begin
        wr_cnt <= wr_cnt - 16'd1;
      end
      if ((wr_state_nx == WR_RESP) && (wr_state != WR_RESP)) begin
        if (wr_slv_nx)      s_axi_bresp <= RESP_SLVERR;
        else if (wr_dec_nx) s_axi_bresp <= RESP_DECERR;
        else                s_axi_bresp <= RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !wr_ill && in_range(wr_addr)) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (s_axi_wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi4_lat_slave_ram.sv
// Directed and randomized bench for axi4_lat_slave_ram against a byte-level
// memory model that derives beat addresses and responses from the burst rules.
module tb_axi4_lat_slave_ram;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int IW = 16;
  localparam int WORDS = 4096;
  localparam longint unsigned BASE = 64'h0;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  int total = 0;
  int bad = 0;

  logic [DW-1:0]   ref_mem [WORDS];
  logic [DW-1:0]   wr_data [16];
  logic [DW/8-1:0] wr_strb [16];
  logic [DW-1:0]   rd_got  [16];
  logic [1:0]      rd_rsp  [16];
  logic [1:0]      bresp_seen;

  axi4_lat_slave_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_WORDS(WORDS),
    .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit m_illegal(int len, int size, int burst);
    return (burst == 3) || (size > 6) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic bit m_in_range(longint unsigned a);
    return (a >= BASE) && ((a - BASE) / 64 < WORDS);
  endfunction

  function automatic longint unsigned m_next(longint unsigned prev, longint unsigned start,
                                             int len, int size, int burst);
    longint unsigned step, nxt, blk, lo;
    step = 64'd1 << size;
    if (burst == 0) return prev;
    nxt = prev - (prev % step) + step;
    if (burst == 2) begin
      blk = longint'(len + 1) * step;
      lo  = start - (start % blk);
      if (nxt >= lo + blk) nxt = nxt - blk;
    end
    return nxt;
  endfunction

  task automatic do_write(input logic [IW-1:0] id, input longint unsigned addr, input int len,
                          input int size, input int burst, input bit bp, input int last_at);
    longint unsigned a;
    bit ill, slv, dec, hs, stalled, first;
    logic [1:0] exp_resp;
    int n, w;
    ill = m_illegal(len, size, burst);
    slv = ill;
    dec = 1'b0;
    a = addr;
    for (int k = 0; k <= len; k++) begin
      if (!m_in_range(a)) dec = 1'b1;
      else if (!ill) begin
        w = int'((a - BASE) / 64);
        for (int b = 0; b < DW/8; b++)
          if (wr_strb[k][b]) ref_mem[w][8*b +: 8] = wr_data[k][8*b +: 8];
      end
      if ((k == last_at) != (k == len)) slv = 1'b1;
      a = m_next(a, addr, len, size, burst);
    end
    exp_resp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);

    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    do begin hs = awready; tick(); n++; end while (!hs && n < 200);
    awvalid = 1'b0;
    check("aw_handshake", hs, 1);
    if (!hs) return;
    check("wready_after_aw", wready, 1);

    for (int k = 0; k <= len; k++) begin
      wdata = wr_data[k]; wstrb = wr_strb[k]; wlast = (k == last_at);
      n = 0;
      do begin
        wvalid = (bp && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        hs = wvalid && wready;
        tick(); n++;
      end while (!hs && n < 200);
      if (!hs) begin
        wvalid = 1'b0;
        check("w_handshake", hs, 1);
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_drop_after_len", wready, 0);

    n = 0; first = 1'b1; stalled = 1'b0; hs = 1'b0;
    while (!hs && n < 200) begin
      if (stalled) check("b_hold", bvalid, 1);
      if (bvalid) begin
        if (first) begin check("b_latency", n, WR_LAT - 1); first = 1'b0; end
        check("bid", bid, id);
        check("bresp", bresp, exp_resp);
      end
      bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = bvalid && bready;
      stalled = bvalid && !bready;
      if (hs) bresp_seen = bresp;
      tick(); n++;
    end
    bready = 1'b0;
    check("b_handshake", hs, 1);
    check("awready_after_b", awready, 1);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input longint unsigned addr, input int len,
                         input int size, input int burst, input bit bp);
    logic [DW-1:0] exp_d [256];
    logic [1:0]    exp_r [256];
    longint unsigned a;
    bit ill, hs, stalled, first;
    int n, k;
    ill = m_illegal(len, size, burst);
    a = addr;
    for (int j = 0; j <= len; j++) begin
      if (ill) begin exp_d[j] = '0; exp_r[j] = 2'b10; end
      else if (!m_in_range(a)) begin exp_d[j] = '0; exp_r[j] = 2'b11; end
      else begin exp_d[j] = ref_mem[int'((a - BASE) / 64)]; exp_r[j] = 2'b00; end
      a = m_next(a, addr, len, size, burst);
    end

    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    n = 0;
    do begin hs = arready; tick(); n++; end while (!hs && n < 200);
    arvalid = 1'b0;
    check("ar_handshake", hs, 1);
    if (!hs) return;
    check("arready_low_after_ar", arready, 0);

    k = 0; n = 0; first = 1'b1; stalled = 1'b0;
    while (k <= len && n < 400) begin
      if (stalled) check("r_hold", rvalid, 1);
      if (rvalid) begin
        if (first) begin check("r_latency", n, RD_LAT - 1); first = 1'b0; end
        check("rdata", rdata, exp_d[k]);
        check("rresp", rresp, exp_r[k]);
        check("rlast", rlast, (k == len));
        check("rid", rid, id);
      end
      rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = rvalid && rready;
      stalled = rvalid && !rready;
      if (hs && k < 16) begin rd_got[k] = rdata; rd_rsp[k] = rresp; end
      tick(); n++;
      if (hs) k++;
    end
    rready = 1'b0;
    check("r_beat_count", k, len + 1);
    check("r_no_extra_beat", rvalid, 0);
    check("arready_after_rlast", arready, 1);
  endtask

  task automatic fill(input bit full_strb, input int len);
    for (int k = 0; k <= len; k++) begin
      wr_data[k] = rnd512();
      wr_strb[k] = full_strb ? '1 : {$urandom, $urandom};
    end
  endtask

  initial begin
    logic [DW-1:0] expw;
    int len, size, burst, last_at;
    longint unsigned addr;

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awvalid = 1'b1; arvalid = 1'b1;
    repeat (3) begin
      tick();
      check("rst_ready", {arready, awready, wready}, 3'b000);
      check("rst_valid", {rvalid, bvalid, rlast}, 3'b000);
      check("rst_id_resp", {rid, bid, rresp, bresp}, '0);
      check("rst_rdata", rdata, '0);
    end
    rst = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
    tick();
    check("ready_after_rst", {arready, awready}, 2'b11);
    repeat (4) tick();
    check("no_burst_from_rst", {rvalid, wready, bvalid}, 3'b000);

    // preload words 0..127 so later reads never hit uninitialised storage
    for (int i = 0; i < 8; i++) begin
      fill(1'b1, 15);
      do_write(16'(i), 64'(i * 16 * 64), 15, 6, 1, 1'b0, 15);
    end

    // INCR write/read at 0x40
    for (int k = 0; k < 4; k++) begin wr_data[k] = DW'(8'hA0 + k); wr_strb[k] = '1; end
    do_write(16'h1234, 64'h40, 3, 6, 1, 1'b0, 3);
    check("incr_bresp", bresp_seen, 2'b00);
    do_read(16'h4321, 64'h40, 3, 6, 1, 1'b0);
    for (int k = 0; k < 4; k++) check("incr_readback", rd_got[k], DW'(8'hA0 + k));

    // WRAP len=3 at 0x0C0 fetches words 3,0,1,2
    do_read(16'h0007, 64'hC0, 3, 6, 2, 1'b0);
    check("wrap_beat0", rd_got[0], ref_mem[3]);
    check("wrap_beat1", rd_got[1], ref_mem[0]);
    check("wrap_beat2", rd_got[2], ref_mem[1]);
    check("wrap_beat3", rd_got[3], ref_mem[2]);

    // strobes
    wr_data[0] = '1; wr_strb[0] = '1;
    do_write(16'h0005, 64'h100, 0, 6, 1, 1'b0, 0);
    wr_data[0] = DW'(32'h11223344); wr_strb[0] = (DW/8)'(4'hF);
    do_write(16'h0006, 64'h100, 0, 6, 1, 1'b0, 0);
    do_read(16'h0008, 64'h100, 0, 6, 1, 1'b0);
    expw = '1;
    expw[31:0] = 32'h11223344;
    check("strobe_merge", rd_got[0], expw);

    // range errors
    do_read(16'h0009, BASE + WORDS * 64, 0, 6, 1, 1'b0);
    check("oor_rdata", rd_got[0], '0);
    check("oor_rresp", rd_rsp[0], 2'b11);
    fill(1'b1, 1);
    do_write(16'h000A, BASE + (WORDS - 1) * 64, 1, 6, 1, 1'b0, 1);
    check("lastword_bresp", bresp_seen, 2'b11);
    do_read(16'h000B, BASE + (WORDS - 1) * 64, 0, 6, 1, 1'b0);
    check("lastword_data", rd_got[0], wr_data[0]);
    fill(1'b1, 2);
    do_write(16'h000C, 64'h40, 2, 6, 2, 1'b0, 2);
    check("wrap_len2_bresp", bresp_seen, 2'b10);
    do_read(16'h000D, 64'h40, 2, 6, 2, 1'b0);
    check("wrap_len2_rresp", rd_rsp[1], 2'b10);
    check("wrap_len2_rdata", rd_got[1], '0);

    // early wlast: all 4 beats still taken, response SLVERR
    fill(1'b1, 3);
    do_write(16'h000E, 64'h200, 3, 6, 1, 1'b1, 1);
    check("wlast_bresp", bresp_seen, 2'b10);
    do_read(16'h000F, 64'h200, 3, 6, 1, 1'b1);

    // randomized bursts with backpressure
    for (int t = 0; t < 24; t++) begin
      burst = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = int'($urandom_range(0, 15));
      addr = 64'($urandom_range(0, 64 * 64 - 1));
      last_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : len;
      fill(1'b0, len);
      do_write(16'($urandom), addr, len, size, burst, 1'b1, last_at);
      do_read(16'($urandom), addr, len, size, burst, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_lat_slave_ram.md
# axi4_lat_slave_ram

Parametrised AXI4 slave memory model for the fake-memory verification environment. It sits behind `noc_axi4_bridge` in place of the fixed `axi_slave_ram`. It adds configurable base address and depth, programmable read/write response latency, FIXED/INCR/WRAP and narrow bursts, byte strobes, and per-beat DECERR/SLVERR reporting. One read burst and one write burst may be in flight concurrently, one per channel.

## Interface
- `ADDR_WIDTH`, 64: AXI address width.
- `DATA_WIDTH`, 512: data width, power of 2, ≥32; `STRB_WIDTH` = `DATA_WIDTH/8`.
- `ID_WIDTH`, 16: AXI ID width.
- `MEM_WORDS`, 4096: depth in `DATA_WIDTH` words, power of 2.
- `BASE_ADDR`, 0: byte address of word 0, aligned to `STRB_WIDTH`.
- `RD_LATENCY`, 4: cycles from AR handshake to first `rvalid`, ≥1.
- `WR_LATENCY`, 2: cycles from last W handshake to `bvalid`, ≥1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axi_aw{id,addr,len,size,burst}` in `ID_WIDTH`/`ADDR_WIDTH`/8/3/2: write address.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata` in `DATA_WIDTH`, `s_axi_wstrb` in `STRB_WIDTH`, `s_axi_wlast` in 1: write data.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data handshake.
- `s_axi_bid` out `ID_WIDTH`, `s_axi_bresp` out 2: write response.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response handshake.
- `s_axi_ar{id,addr,len,size,burst}` in: read address, widths as AW.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address handshake.
- `s_axi_rid` out `ID_WIDTH`, `s_axi_rdata` out `DATA_WIDTH`, `s_axi_rresp` out 2, `s_axi_rlast` out 1: read data.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data handshake.

## Operation
- **Beat address.** Beat 0 uses the request address. Later beats:
  - FIXED: unchanged.
  - INCR: previous address aligned down to 2^size, plus 2^size.
  - WRAP: as INCR, wrapping within an aligned block of (len+1)·2^size bytes.
- **Word index.** Index = (beat_addr − `BASE_ADDR`) >> log2(`STRB_WIDTH`). A beat is in range iff beat_addr ≥ `BASE_ADDR` and index < `MEM_WORDS`.
- **Illegal request:** WRAP with len ∉ {1,3,7,15}, size > log2(`STRB_WIDTH`), or burst = 2'b11.
  - Burst still runs its len+1 beats.
  - No memory write.
  - rdata is 0.
  - Every R beat carries SLVERR (2'b10); bresp is SLVERR.
- **Read FSM** RD_IDLE → RD_WAIT → RD_BURST → RD_IDLE.
  - `arready`=1 only in RD_IDLE.
  - RD_WAIT counts `RD_LATENCY`−1 cycles.
  - RD_BURST drives one beat per `rready` handshake with no bubbles.
  - rdata is the full memory word; narrow-beat lane selection is left to the master.
  - Out-of-range beat: rdata=0, rresp=DECERR (2'b11). Otherwise OKAY.
  - `rlast`=1 on beat len. `rid`=`arid`.
- **Write FSM** WR_IDLE → WR_DATA → WR_WAIT → WR_RESP → WR_IDLE.
  - `awready`=1 only in WR_IDLE; `wready`=1 only in WR_DATA.
  - Each W handshake writes the bytes selected by `wstrb` of the in-range word.
  - Out-of-range beats are discarded.
  - The burst ends after len+1 beats regardless of `wlast`.
  - `bresp` priority: SLVERR (illegal request, or `wlast` value ≠ (beat==len) on any beat), then DECERR (any beat out of range), else OKAY.
  - `bid`=`awid`.
- **Channel independence.** Read and write FSMs are independent. If a read fetch and a write hit the same word in the same cycle, the read returns the old data.
- **Memory contents** are not reset; uninitialised words read as X in simulation.

## Timing
- **Reset values.** All outputs are registered.
  - While `rst`=1: every ready, valid and `rlast` = 0; data/id/resp = 0.
  - `arready`/`awready` rise the first cycle after `rst` falls.
- **Reset mid-burst:** both FSMs return to IDLE next cycle. No R/B is issued for abandoned bursts; already-written beats remain in memory.
- **Read timing.**
  - AR handshake at cycle T: `arready`=0 at T+1, first `rvalid` at T+`RD_LATENCY`.
  - With `rready` held high, beat k is valid at T+`RD_LATENCY`+k.
  - `arready` returns the cycle after the `rlast` handshake.
- **Write timing.**
  - AW handshake at T: `wready`=1 from T+1.
  - Last W handshake at cycle L: `bvalid` at L+`WR_LATENCY`; held until `bready`.
  - `awready` returns the cycle after the B handshake.
- **Stability:** valid, data, id, resp and last hold stable while valid=1 and ready=0.
- **Throughput:** one beat/cycle per channel; R and W beats may occur in the same cycle.

## Test plan
- **Reset:** hold `rst` 3 cycles with `arvalid`=`awvalid`=1 → all outputs 0 during reset; `arready`=`awready`=1 one cycle after release; no handshake accepted during reset.
- **INCR write/read:** INCR len=3 size=6 write at 0x40, data 0xA0..0xA3, full strobes → `bvalid` 2 cycles after the last W (`WR_LATENCY`=2), bresp OKAY. Read back at 0x40 → first `rvalid` 4 cycles after AR, data 0xA0..0xA3, `rlast` on beat 3, rresp OKAY, rid matches.
- **WRAP read:** WRAP len=3 size=6 at 0x0C0 → words fetched in order 0x0C0, 0x000, 0x040, 0x080.
- **Strobes:** write strobe 0x0F over word 0xFF..FF with data 0x11223344 → readback low 4 bytes 0x11223344, all other bytes 0xFF.
- **Range errors:**
  - Read at `BASE_ADDR`+`MEM_WORDS`·64 → rdata 0, rresp DECERR.
  - INCR len=1 write starting at the last word → in-range beat written, bresp DECERR.
  - WRAP len=2 → SLVERR.
- **Backpressure and `wlast`:** random `rready`/`bready` stalls → no beat lost or duplicated, outputs stable while stalled. `wlast` asserted on beat 1 of a len=3 burst → 4 beats still accepted, bresp SLVERR.
